// File: rtl/lfsr_checker.sv
// Receive-side PRBS checker. It predicts each word from the previous one, locks after a run of matches, and counts mismatches while locked.
// Optional LFSR_CHECK_ZERO_EN: an all-zero word is always a mismatch and sets the sticky stuck flag.
module lfsr_checker #(
   parameter int unsigned N_BIT      = 5,
   parameter int unsigned STAGE_1    = 2,
   parameter int unsigned STAGE_2    = 5,
   parameter int unsigned LOCK_COUNT = 4,
   parameter int unsigned LOSS_COUNT = 3,
   parameter int unsigned ERR_BITS   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   input  logic [N_BIT-1:0]    data_in,
   input  logic                clear,
   output logic                locked,
   output logic                error,
   output logic [ERR_BITS-1:0] err_count,
   output logic                stuck
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t               state;
   logic [N_BIT-1:0]     prev;
   logic                 have_prev;
   logic [CNT_W-1:0]     match_cnt;
   logic [CNT_W-1:0]     miss_cnt;

   logic [N_BIT-1:0]     predicted;
   logic                 bad_zero;
   logic                 match;
   logic                 compare;
   logic                 counted;
   logic [ERR_BITS-1:0]  err_base;
   logic [ERR_BITS-1:0]  err_next;

   assign predicted = {prev[N_BIT-2:0], prev[STAGE_2-1] ^ prev[STAGE_1-1]};

`ifdef LFSR_CHECK_ZERO_EN
   assign bad_zero = (data_in == '0);
`else
   assign bad_zero = 1'b0;
`endif

   assign match   = (data_in == predicted) && !bad_zero;
   assign compare = enable && have_prev;
   assign counted = compare && !match && (state == LOCKED);

   // Clear applies first, so a counted mismatch on the same edge leaves a count of one.
   assign err_base = clear ? '0 : err_count;
   assign err_next = (counted && (err_base != '1)) ? err_base + ERR_BITS'(1) : err_base;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= HUNT;
         prev      <= '0;
         have_prev <= 1'b0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         locked    <= 1'b0;
         error     <= 1'b0;
         err_count <= '0;
      end else begin
         error     <= 1'b0;
         err_count <= err_next;
         if (enable) begin
            prev      <= data_in;
            have_prev <= 1'b1;
         end
         if (compare) begin
            case (state)
               HUNT: begin
                  if (!match) begin
                     match_cnt <= '0;
                  end else if (match_cnt == CNT_W'(LOCK_COUNT - 1)) begin
                     state     <= LOCKED;
                     locked    <= 1'b1;
                     match_cnt <= '0;
                     miss_cnt  <= '0;
                  end else begin
                     match_cnt <= match_cnt + CNT_W'(1);
                  end
               end
               LOCKED: begin
                  if (match) begin
                     miss_cnt <= '0;
                  end else begin
                     error <= 1'b1;
                     // The mismatch that drops lock is still counted above.
                     if (miss_cnt == CNT_W'(LOSS_COUNT - 1)) begin
                        state     <= HUNT;
                        locked    <= 1'b0;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                     end else begin
                        miss_cnt <= miss_cnt + CNT_W'(1);
                     end
                  end
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

`ifdef LFSR_CHECK_ZERO_EN
   // Sticky lock-up indicator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stuck <= 1'b0;
      else if (enable && bad_zero)
         stuck <= 1'b1;
   end
`else
   assign stuck = 1'b0;
`endif

endmodule
